seq_match_logger: RTL and testbench
===================================

Name: seq_match_logger

Overview:
- Downstream stage of the 5-symbol sequence detector; consumes its one-cycle `match` output.
- Timestamps every match against a free-running cycle counter and buffers the timestamps in a small FIFO.
- Software or a bus bridge drains the FIFO through a valid/ready port.
- Keeps saturating counts of total matches and of matches dropped on overflow.

Parameters:
- TS_WIDTH, 16, width of the timestamp counter and of each logged entry.
- DEPTH, 4, FIFO entries; must be a power of two, 2 or greater.
- CNT_WIDTH, 8, width of match_count and drop_count.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- match  input  1  match pulse from the detector, sampled on every rising clk edge
- out_valid  output  1  FIFO head entry is available
- out_ready  input  1  consumer accepts the head entry
- out_ts  output  TS_WIDTH  head entry; 0 when empty
- match_count  output  CNT_WIDTH  total matches seen, saturating
- drop_count  output  CNT_WIDTH  matches lost because the FIFO was full, saturating
- full  output  1  occupancy equals DEPTH
- empty  output  1  occupancy equals 0

Behaviour:
- Reset (reset=1 at a rising edge): ts=0, occupancy=0, read/write pointers=0, match_count=0, drop_count=0.
  - Outputs after reset: out_valid=0, out_ts=0, full=0, empty=1.
  - Reset overrides all other activity in that cycle, including a simultaneous match or pop. Mid-operation reset discards all FIFO contents.
- Timestamp: ts is a free-running counter.
  - ts=0 in the first cycle after reset is released, then increments by 1 every cycle.
  - It wraps modulo 2^TS_WIDTH and has no saturation.
- Logged value: the ts value of the cycle in which match=1 is sampled, before that cycle's increment.
- Pop: pop = out_valid && out_ready. The head is removed at that edge.
- Push: push = match && (!full || pop).
  - When full, a simultaneous pop frees a slot, so the match is logged and occupancy stays at DEPTH.
- Drop: match && full && !pop. The entry is discarded and drop_count increments, saturating at all-ones.
- match_count: increments on every sampled match, whether logged or dropped; saturates at all-ones.
- Occupancy transitions, with range 0..DEPTH:
  - push and no pop: +1
  - pop and no push: -1
  - both: unchanged
  - neither: unchanged
- Pointers are log2(DEPTH) bits wide and wrap naturally.
- FIFO is first-word-fall-through:
  - out_valid = !empty; out_ts = mem[rd_ptr] when non-empty, else 0.
  - Latency: match sampled at edge N into an empty FIFO gives out_valid=1 and out_ts=logged value in the cycle after edge N.
- Push and pop on an empty FIFO in the same cycle cannot occur, because out_valid=0; the push proceeds normally.
- Handshake rules:
  - out_ts must hold stable while out_valid=1 and out_ready=0.
  - out_ready while empty has no effect.
- match is accepted on consecutive cycles even though the detector never produces that pattern.
- full and empty are registered-equivalent decodes of occupancy, with no combinational path from match.

Optional Feature:
- Macro: SEQ_LOG_DELTA_EN.
- Defined: entries hold the gap instead of the absolute timestamp.
  - Gap register: reset to 0, increments each cycle, saturates at all-ones.
  - A match logs the current gap value; gap loads 1 at that edge.
  - A dropped match still reloads the gap.
  - The first match after reset logs the cycles elapsed since reset release.
  - ts, and its wrap behaviour, is then unused for entries.
- Undefined: absolute ts is logged, and no gap register exists.

Test Plan:
- Reset release, match=1 in cycle 5 only, out_ready=0 -> from cycle 6: out_valid=1, out_ts=5, match_count=1, empty=0; out_ts held stable for 10 cycles.
- Matches in cycles 3, 9, 20, 31, 40 with out_ready=0 and DEPTH=4 -> full=1 after the 4th; drop_count=1, match_count=5; draining yields 3, 9, 20, 31, then empty=1, out_ts=0.
- FIFO full, match=1 and out_ready=1 in the same cycle -> no drop; occupancy stays 4; head advances; the new entry is appended last.
- Reset asserted with 3 entries queued and match=1 in that cycle -> next cycle: empty=1, out_valid=0, match_count=0, drop_count=0, and ts restarts at 0.
- Run 65540 cycles with a match at cycle 65537 (TS_WIDTH=16) -> logged value 1 (wrap); 300 matches with out_ready=1 -> match_count saturates at 255.
- SEQ_LOG_DELTA_EN defined, matches in cycles 4, 10, 11 -> entries 4, 6, 1; no match for 70000 cycles -> next entry 65535.

Source files
------------

// File: rtl/seq_match_logger.sv
// seq_match_logger
// Timestamps each one-cycle match pulse from the sequence detector and
// queues the timestamps in a first-word-fall-through FIFO that is drained
// through a valid/ready port. Saturating counters track total matches and
// matches dropped because the FIFO was full.
//
// Optional feature macro: SEQ_LOG_DELTA_EN
//   undefined (default): each entry holds the absolute free-running ts value
//   defined            : each entry holds the gap in cycles since the previous
//                        match (or since reset release), saturating at all-ones
`default_nettype none

module seq_match_logger #(
   parameter int TS_WIDTH  = 16,
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 match,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [TS_WIDTH-1:0]  out_ts,
   output logic [CNT_WIDTH-1:0] match_count,
   output logic [CNT_WIDTH-1:0] drop_count,
   output logic                 full,
   output logic                 empty
);

   localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0]    LP_FULL = (PW+1)'(DEPTH);

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] f_sat_cnt(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [TS_WIDTH-1:0]  r_mem [DEPTH];
   logic [PW-1:0]        r_rd;
   logic [PW-1:0]        r_wr;
   logic [PW:0]          r_occ;
   logic [CNT_WIDTH-1:0] r_mcnt;
   logic [CNT_WIDTH-1:0] r_dcnt;

   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;
   logic [TS_WIDTH-1:0]  w_log_val;

   // full/empty decode only the occupancy register, so there is no
   // combinational path from match to these flags.
   assign full        = (r_occ == LP_FULL);
   assign empty       = (r_occ == '0);
   assign out_valid   = !empty;
   assign out_ts      = empty ? '0 : r_mem[r_rd];
   assign match_count = r_mcnt;
   assign drop_count  = r_dcnt;

   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign w_pop  = out_valid && out_ready;
   assign w_push = match && (!full || w_pop);
   assign w_drop = match && full && !w_pop;

`ifdef SEQ_LOG_DELTA_EN
   // Gap increment that sticks at all-ones for long idle stretches.
   function automatic logic [TS_WIDTH-1:0] f_sat_gap(input logic [TS_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [TS_WIDTH-1:0] r_gap;

   assign w_log_val = r_gap;

   // Gap since the previous match; any match (logged or dropped) restarts it at 1.
   always_ff @(posedge clk) begin
      if (reset)      r_gap <= '0;
      else if (match) r_gap <= TS_WIDTH'(1);
      else            r_gap <= f_sat_gap(r_gap);
   end
`else
   logic [TS_WIDTH-1:0] r_ts;

   assign w_log_val = r_ts;

   // Free-running timestamp, wraps modulo 2^TS_WIDTH.
   always_ff @(posedge clk) begin
      if (reset) r_ts <= '0;
      else       r_ts <= r_ts + 1'b1;
   end
`endif

   // FIFO pointers, occupancy and the saturating match/drop counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd   <= '0;
         r_wr   <= '0;
         r_occ  <= '0;
         r_mcnt <= '0;
         r_dcnt <= '0;
      end else begin
         if (w_pop)  r_rd <= r_rd + 1'b1;
         if (w_push) r_wr <= r_wr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
         if (match)  r_mcnt <= f_sat_cnt(r_mcnt);
         if (w_drop) r_dcnt <= f_sat_cnt(r_dcnt);
      end
   end

   // Entry storage; contents are only meaningful between rd and wr pointers.
   always_ff @(posedge clk) begin
      if (!reset && w_push) r_mem[r_wr] <= w_log_val;
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_match_logger.sv
// Self-checking bench for seq_match_logger: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_seq_match_logger;

   localparam int TS_W  = 16;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int GAP_MAX = (1 << TS_W) - 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              match;
   logic              out_ready;
   logic              out_valid;
   logic [TS_W-1:0]   out_ts;
   logic [CNT_W-1:0]  match_count;
   logic [CNT_W-1:0]  drop_count;
   logic              full;
   logic              empty;

   seq_match_logger #(.TS_WIDTH(TS_W), .DEPTH(DEPTH), .CNT_WIDTH(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .match       (match),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ts      (out_ts),
      .match_count (match_count),
      .drop_count  (drop_count),
      .full        (full),
      .empty       (empty)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int mq[$];
   int m_ts;
   int m_gap;
   int m_mc;
   int m_dc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input logic m, input logic r, input logic rst);
      bit pop;
      bit fl;
      int v;
      if (rst) begin
         mq.delete();
         m_ts = 0; m_gap = 0; m_mc = 0; m_dc = 0;
      end else begin
         pop = (mq.size() != 0) && r;
         fl  = (mq.size() == DEPTH);
`ifdef SEQ_LOG_DELTA_EN
         v = m_gap;
`else
         v = m_ts;
`endif
         if (pop) void'(mq.pop_front());
         if (m) begin
            if (m_mc < CNT_MAX) m_mc++;
            if (!fl || pop) mq.push_back(v);
            else if (m_dc < CNT_MAX) m_dc++;
         end
         m_ts = (m_ts + 1) % (1 << TS_W);
         if (m) m_gap = 1;
         else if (m_gap < GAP_MAX) m_gap++;
      end
   endtask

   task automatic check_outputs();
      int head;
      head = (mq.size() != 0) ? mq[0] : 0;
      chk("out_valid",   32'(out_valid),   32'(mq.size() != 0));
      chk("out_ts",      32'(out_ts),      32'(head));
      chk("full",        32'(full),        32'(mq.size() == DEPTH));
      chk("empty",       32'(empty),       32'(mq.size() == 0));
      chk("match_count", 32'(match_count), 32'(m_mc));
      chk("drop_count",  32'(drop_count),  32'(m_dc));
   endtask

   // One clock cycle: check current outputs, drive inputs, predict, advance.
   task automatic cyc(input logic m, input logic r, input logic rst);
      check_outputs();
      reset = rst; match = m; out_ready = r;
      model_step(m, r, rst);
      @(negedge clk);
   endtask

   int exp2 [4];

   initial begin
      reset = 1'b1; match = 1'b0; out_ready = 1'b0;
      model_step(1'b0, 1'b0, 1'b1);
      repeat (2) @(negedge clk);

      // Single match in cycle 5, held at the head with out_ready low
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      for (int c = 0; c < 17; c++) begin
         if (c >= 6) begin
            chk("p1_ts",    32'(out_ts), 32'd5);
            chk("p1_valid", 32'(out_valid), 32'd1);
         end
         if (c == 6) chk("p1_mcnt", 32'(match_count), 32'd1);
         cyc(c == 5, 0, 0);
      end

      // Five matches into a depth-4 FIFO, then drain
      cyc(0, 0, 1);
      for (int c = 0; c <= 40; c++)
         cyc((c == 3) || (c == 9) || (c == 20) || (c == 31) || (c == 40), 0, 0);
      chk("p2_full", 32'(full), 32'd1);
      chk("p2_drop", 32'(drop_count), 32'd1);
      chk("p2_mcnt", 32'(match_count), 32'd5);
`ifdef SEQ_LOG_DELTA_EN
      exp2 = '{3, 6, 11, 11};
`else
      exp2 = '{3, 9, 20, 31};
`endif
      for (int i = 0; i < 4; i++) begin
         chk("p2_drain", 32'(out_ts), 32'(exp2[i]));
         cyc(0, 1, 0);
      end
      chk("p2_empty", 32'(empty), 32'd1);
      chk("p2_ts0",   32'(out_ts), 32'd0);

      // Full FIFO with simultaneous match and pop
      repeat (4) cyc(1, 0, 0);
      chk("p3_full_before", 32'(full), 32'd1);
      cyc(1, 1, 0);
      chk("p3_full_after", 32'(full), 32'd1);
      chk("p3_no_drop",    32'(drop_count), 32'd1);
      cyc(0, 0, 0);

      // Reset with three entries queued and a match in the same cycle
      cyc(0, 1, 0);
      cyc(1, 0, 1);
      chk("p4_empty", 32'(empty), 32'd1);
      chk("p4_valid", 32'(out_valid), 32'd0);
      chk("p4_mcnt",  32'(match_count), 32'd0);
      chk("p4_dcnt",  32'(drop_count), 32'd0);
      cyc(1, 0, 0);
      chk("p4_ts_restart", 32'(out_ts), 32'd0);

      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++)
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
             $urandom_range(0, 127) == 0);

      // Timestamp wrap / gap saturation, then match_count saturation
      cyc(0, 0, 1);
      for (int c = 0; c <= 65537; c++) cyc(c == 65537, 0, 0);
`ifdef SEQ_LOG_DELTA_EN
      chk("p6_wrap", 32'(out_ts), 32'd65535);
`else
      chk("p6_wrap", 32'(out_ts), 32'd1);
`endif
      for (int i = 0; i < 300; i++) cyc(1, 1, 0);
      chk("p6_mcnt_sat", 32'(match_count), 32'd255);
      cyc(0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
